// File: rtl/if_id_reg_if.sv
// IF/ID pipeline register bus: fetch-side inputs plus registered outputs to decode.
// master = IF stage / hazard unit side, slave = the pipeline register itself.
interface if_id_reg_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic [ADDR_W-1:0] addr_i;
    logic [INST_W-1:0] inst_i;
    logic              write_i;
    logic              flush_i;
    logic [ADDR_W-1:0] addr_o;
    logic [INST_W-1:0] inst_o;
    logic              valid_o;

    modport master (
        output addr_i,
        output inst_i,
        output write_i,
        output flush_i,
        input  addr_o,
        input  inst_o,
        input  valid_o
    );

    modport slave (
        input  addr_i,
        input  inst_i,
        input  write_i,
        input  flush_i,
        output addr_o,
        output inst_o,
        output valid_o
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall (write_i low holds) and a valid flag for decode.
// Define IF_ID_FLUSH_EN to make flush_i load a bubble with priority over write_i.
module if_id_reg #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
    input  logic        clk_i,
    input  logic        start_i,
    if_id_reg_if.slave  bus
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;

    // Hold is the default so X on the data inputs cannot leak in during a stall.
    always_comb begin
        addr_d  = addr_q;
        inst_d  = inst_q;
        valid_d = valid_q;
`ifdef IF_ID_FLUSH_EN
        if (bus.flush_i) begin
            addr_d  = '0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (bus.write_i) begin
            addr_d  = bus.addr_i;
            inst_d  = bus.inst_i;
            valid_d = 1'b1;
        end
`else
        if (bus.write_i) begin
            addr_d  = bus.addr_i;
            inst_d  = bus.inst_i;
            valid_d = 1'b1;
        end
`endif
    end

`ifndef IF_ID_FLUSH_EN
    wire unused_flush = bus.flush_i;
`endif

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign bus.addr_o  = addr_q;
    assign bus.inst_o  = inst_q;
    assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: a reference model pushes expected outputs to a
// scoreboard as each edge's stimulus is driven; they are popped and compared after the edge.
module tb_if_id_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
        logic        v;
    } exp_t;

    logic clk;
    logic start_i = 1'b1;

    if_id_reg_if #(.ADDR_W(32), .INST_W(32)) bus ();

    if_id_reg #(.ADDR_W(32), .INST_W(32), .NOP_INST(NOP)) dut (
        .clk_i   (clk),
        .start_i (start_i),
        .bus     (bus.slave)
    );

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] m_addr;
    logic [31:0] m_inst;
    logic        m_valid;
    int          vectors;
    int          miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Drive one edge of stimulus at the falling edge, predict, then step past the rising edge.
    task automatic drive(input logic st, input logic [31:0] a, input logic [31:0] i,
                         input logic w, input logic f);
        @(negedge clk);
        start_i     = st;
        bus.addr_i  = a;
        bus.inst_i  = i;
        bus.write_i = w;
        bus.flush_i = f;
        if (!st) begin
            m_addr = '0; m_inst = NOP; m_valid = 1'b0;
`ifdef IF_ID_FLUSH_EN
        end else if (f) begin
            m_addr = '0; m_inst = NOP; m_valid = 1'b0;
`endif
        end else if (w) begin
            m_addr = a; m_inst = i; m_valid = 1'b1;
        end
        sb.push_back('{m_addr, m_inst, m_valid});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.addr_i = 32'd5; bus.inst_i = 32'd0; bus.write_i = 1'b1; bus.flush_i = 1'b0;
        m_addr = '0; m_inst = NOP; m_valid = 1'b0;
        #1 start_i = 1'b0;
        #2;
        vectors++;
        if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {32'h0, NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async: got %h/%h/%b, expected %h/%h/%b",
                     bus.addr_o, bus.inst_o, bus.valid_o, 32'h0, NOP, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'd5, 32'd0, 1'b1, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {e.a, e.i, e.v}) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h/%h/%b, expected %h/%h/%b",
                         k, bus.addr_o, bus.inst_o, bus.valid_o, e.a, e.i, e.v);
            end
        end
        drive(1'b1, 32'd5, 32'd0, 1'b1, 1'b0);
        e = sb.pop_front();
        vectors++;
        if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {e.a, e.i, e.v}) begin
            miscompares++;
            $display("FAIL reset_release: got %h/%h/%b, expected %h/%h/%b",
                     bus.addr_o, bus.inst_o, bus.valid_o, e.a, e.i, e.v);
        end
    endtask

    // Re-enter reset, release with write_i low and incrementing inputs, then start loading.
    task automatic test_stall_then_load();
        drive(1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'd5 + k, 32'd0 + k, 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {e.a, e.i, e.v}) begin
                miscompares++;
                $display("FAIL stall_from_start[%0d]: got %h/%h/%b, expected %h/%h/%b",
                         k, bus.addr_o, bus.inst_o, bus.valid_o, e.a, e.i, e.v);
            end
        end
        for (int k = 3; k < 7; k++) begin
            drive(1'b1, 32'd5 + k, 32'd0 + k, 1'b1, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {e.a, e.i, e.v}) begin
                miscompares++;
                $display("FAIL load[%0d]: got %h/%h/%b, expected %h/%h/%b",
                         k, bus.addr_o, bus.inst_o, bus.valid_o, e.a, e.i, e.v);
            end
        end
    endtask

    task automatic test_mid_stall();
        drive(1'b1, 32'h40, 32'h8C22_0004, 1'b1, 1'b0);
        void'(sb.pop_front());
        drive(1'b1, 32'h44, 32'h1111_1111, 1'b0, 1'b0);
        drive(1'b1, 32'hxxxx_xxxx, 32'hzzzz_zzzz, 1'b0, 1'b0);
        drive(1'b1, 32'h4C, 32'h2222_2222, 1'b0, 1'b0);
        drive(1'b1, 32'h50, 32'h3333_3333, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            vectors++;
            if (k < 3 && {e.a, e.i, e.v} !== {32'h40, 32'h8C22_0004, 1'b1}) begin
                miscompares++;
                $display("FAIL mid_stall_model[%0d]: got %h/%h/%b, expected 40/8c220004/1",
                         k, e.a, e.i, e.v);
            end
        end
        if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {e.a, e.i, e.v}) begin
            miscompares++;
            $display("FAIL mid_stall_resume: got %h/%h/%b, expected %h/%h/%b",
                     bus.addr_o, bus.inst_o, bus.valid_o, e.a, e.i, e.v);
        end
        // Re-run the stall with per-edge checks so a leak on any held edge is caught.
        drive(1'b1, 32'h40, 32'h8C22_0004, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, (k == 1) ? 32'hxxxx_xxxx : 32'h60 + k, 32'hA0 + k, 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {32'h40, 32'h8C22_0004, 1'b1}) begin
                miscompares++;
                $display("FAIL mid_stall_hold[%0d]: got %h/%h/%b, expected 40/8c220004/1",
                         k, bus.addr_o, bus.inst_o, bus.valid_o);
            end
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h44, 32'h0043_0820, 1'b1, 1'b0);
        drive(1'b1, 32'h58, 32'hDEAD_BEEF, 1'b1, 1'b1);
        drive(1'b1, 32'h5C, 32'hCAFE_F00D, 1'b1, 1'b0);
        drive(1'b1, 32'h60, 32'h0BAD_F00D, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            if (k == 2) begin
                drive(1'b1, 32'h64, 32'h1357_9BDF, 1'b0, 1'b0);
            end
        end
        // Replay with per-edge comparisons.
        drive(1'b1, 32'h44, 32'h0043_0820, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) void'(sb.pop_front());
        vectors++;
        if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {32'h44, 32'h0043_0820, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_setup: got %h/%h/%b, expected 44/00430820/1",
                     bus.addr_o, bus.inst_o, bus.valid_o);
        end
        drive(1'b1, 32'h58, 32'hDEAD_BEEF, 1'b1, 1'b1);
        e = sb.pop_front();
        vectors++;
        if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {e.a, e.i, e.v}) begin
            miscompares++;
            $display("FAIL flush_with_write: got %h/%h/%b, expected %h/%h/%b",
                     bus.addr_o, bus.inst_o, bus.valid_o, e.a, e.i, e.v);
        end
        drive(1'b1, 32'h5C, 32'hCAFE_F00D, 1'b1, 1'b0);
        void'(sb.pop_front());
        drive(1'b1, 32'h60, 32'h0BAD_F00D, 1'b0, 1'b1);
        e = sb.pop_front();
        vectors++;
        if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {e.a, e.i, e.v}) begin
            miscompares++;
            $display("FAIL flush_no_write: got %h/%h/%b, expected %h/%h/%b",
                     bus.addr_o, bus.inst_o, bus.valid_o, e.a, e.i, e.v);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h48, 32'h1234_5678, 1'b1, 1'b0);
        void'(sb.pop_front());
        @(negedge clk);
        bus.write_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.addr_i  = 32'h99;
        #1 start_i = 1'b0;
        #1;
        vectors++;
        if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {32'h0, NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got %h/%h/%b, expected %h/%h/%b",
                     bus.addr_o, bus.inst_o, bus.valid_o, 32'h0, NOP, 1'b0);
        end
        m_addr = '0; m_inst = NOP; m_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {32'h0, NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset_over_write: got %h/%h/%b, expected %h/%h/%b",
                     bus.addr_o, bus.inst_o, bus.valid_o, 32'h0, NOP, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, i;
        logic        w, f;
        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            i = $urandom;
            w = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 5) == 0);
            drive(1'b1, a, i, w, f);
            e = sb.pop_front();
            vectors++;
            if ({bus.addr_o, bus.inst_o, bus.valid_o} !== {e.a, e.i, e.v}) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %h/%h/%b, expected %h/%h/%b",
                         k, bus.addr_o, bus.inst_o, bus.valid_o, e.a, e.i, e.v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_stall_then_load();
        test_mid_stall();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the Instruction Fetch (IF) and Instruction Decode (ID) stages of the 5-stage CPU.
- Each clock it captures the fetched PC/address and the instruction word, gated by a write-enable from the hazard unit.
- When write is low it holds its contents, which implements a stall.
- Also provides a flush path, which inserts a bubble, and a valid flag for the ID stage.

Parameters:
- ADDR_W, 32, width of the address/PC field
- INST_W, 32, width of the instruction field
- NOP_INST, 32'h0000_0000, instruction word loaded on reset/flush (bubble)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- start_i  in  1  reset, active-low, asynchronous; low = reset, high = run
- addr_i  in  ADDR_W  address/PC from the IF stage
- inst_i  in  INST_W  instruction word from instruction memory
- write_i  in  1  IF/ID write enable from the hazard unit; 1 = load, 0 = hold (stall)
- flush_i  in  1  flush request; 1 = load bubble (active only with IF_ID_FLUSH_EN)
- addr_o  out  ADDR_W  registered address to the ID stage
- inst_o  out  INST_W  registered instruction to the ID stage
- valid_o  out  1  1 = addr_o/inst_o hold a real fetched instruction; 0 = bubble/reset

Behaviour:
- Reset: start_i low asynchronously forces addr_o=0, inst_o=NOP_INST, valid_o=0, immediately and without waiting for a clock edge. Outputs stay there while start_i is low.
- Reset release: start_i rising takes effect at the next clk_i rising edge. There is no synchronous reset path.
- Latency: one cycle. Values present on addr_i/inst_i at rising edge N appear on addr_o/inst_o right after edge N, if loaded.
- Per rising edge with start_i high, priority is:
  1. flush_i=1 (feature enabled): addr_o<=0, inst_o<=NOP_INST, valid_o<=0. write_i is ignored.
  2. write_i=1: addr_o<=addr_i, inst_o<=inst_i, valid_o<=1.
  3. write_i=0: all outputs hold their previous values, including valid_o. Stall cycles are unbounded.
- Outputs are purely registered, with no combinational path from any input to any output.
- write_i held low continuously from reset keeps the reset values (0, NOP_INST, 0) indefinitely.
- Reset asserted mid-operation overrides any pending write or flush in the same cycle.
- Width rules: fields are stored verbatim, with no truncation, extension or arithmetic. ADDR_W and INST_W are independent.
- X/Z on addr_i/inst_i while write_i=0 must not disturb the held outputs.

Optional Feature:
- Macro: IF_ID_FLUSH_EN.
- Defined: flush_i behaves as described above, with priority over write_i.
- Undefined: flush_i is present but ignored (no logic depends on it). Register updates depend only on write_i and reset.
- Reset behaviour is identical in both builds.

Test Plan:
- Reset: start_i=0 at t=0, clock running, addr_i=5, inst_i=0, write_i=1 -> addr_o=0, inst_o=0, valid_o=0 until start_i goes high. The first edge after release loads the current inputs.
- Stall from start: release reset with write_i=0. Inputs increment each edge (addr_i 5,6,7…, inst_i 0,1,2…) -> outputs remain 0/0/valid 0 for every edge while write_i=0.
- Load: write_i goes 1 at edge 2, with inputs incrementing -> from edge 3 on, outputs equal the inputs sampled at the previous edge (e.g. addr_i=8, inst_i=3 sampled -> addr_o=8, inst_o=3, valid_o=1). Outputs track with 1-cycle lag.
- Mid-run stall: load addr_i=32'h40, inst_i=32'h8C220004. Drop write_i for 3 edges while inputs change -> outputs hold 0x40/0x8C220004/valid 1. On write_i=1 they resume tracking.
- Flush (IF_ID_FLUSH_EN defined): outputs hold 0x44/0x00430820. Assert flush_i with write_i=1 for one edge -> addr_o=0, inst_o=NOP_INST, valid_o=0. With the macro undefined, the same stimulus loads the inputs instead.
- Async reset mid-run: outputs at 0x48/0x12345678. Pull start_i low between clock edges -> outputs clear immediately, before the next rising edge.
